// File: rtl/frame_scan_sequencer_pkg.sv
// Purpose : shared definitions for the frame scan sequencer: default frame
//           geometry, scan FSM state type, stride encoding and the helper
//           that finds the last stride-aligned index along one axis.
// Ports   : none (package)
package scan_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 640;
  localparam int CW_DEF    = 10;
  localparam int KSIZE_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encoding of the stride2 input / latched stride selector
  localparam logic STRIDE_1 = 1'b0;
  localparam logic STRIDE_2 = 1'b1;

  // Largest multiple of step that still lies inside [0, size-1]
  function automatic int last_index(input int size, input int step);
    return ((size - 1) / step) * step;
  endfunction

endpackage

// File: rtl/axis_stride_counter.sv
// Purpose : one scan axis. Counts 0, S, 2S, ... up to limit, then wraps to 0
//           on the next enabled step. wrap flags that the current count is
//           the final aligned position.
// Ports   : clk, rst (async, active high), clear (sync restart at 0),
//           enable (advance one stride), stride (1 or 2), limit (last aligned
//           index) -> count (current index), wrap (count is last position)
module axis_stride_counter
  import scan_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [1:0]    stride,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] r_count;
  logic [CW:0]   w_next;

  // One extra bit so count+stride at the top of the range cannot overflow
  assign w_next = {1'b0, r_count} + {{(CW-1){1'b0}}, stride};
  assign wrap   = (w_next > {1'b0, limit});
  assign count  = r_count;

  // Axis position register: restart, hold, advance or wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CW{1'b0}};
    end else if (clear) begin
      r_count <= {CW{1'b0}};
    end else if (enable) begin
      if (wrap) begin
        r_count <= {CW{1'b0}};
      end else begin
        r_count <= w_next[CW-1:0];
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/frame_scan_sequencer.sv
// Purpose : walks window centres over an IMG_W x IMG_H feature map at stride
//           1 or 2, one coordinate per valid/ready handshake, with border
//           flags for zero padding and a one-cycle done pulse.
// Ports   : clk, rst (async, active high); start, stride2, abort from the
//           layer controller; out_ready from the consumer; out_valid, row,
//           col, pad_*, last_col, last_frame to the consumer; busy, done
//           back to the layer controller.
module frame_scan_sequencer
  import scan_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = CW_DEF,
  parameter int KSIZE = KSIZE_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stride2,
  input  logic          abort,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          pad_top,
  output logic          pad_bottom,
  output logic          pad_left,
  output logic          pad_right,
  output logic          last_col,
  output logic          last_frame,
  output logic          busy,
  output logic          done
);

  localparam int R = (KSIZE - 1) / 2;

  localparam logic [CW-1:0] LC_S1   = CW'(last_index(IMG_W, 1));
  localparam logic [CW-1:0] LC_S2   = CW'(last_index(IMG_W, 2));
  localparam logic [CW-1:0] LR_S1   = CW'(last_index(IMG_H, 1));
  localparam logic [CW-1:0] LR_S2   = CW'(last_index(IMG_H, 2));
  localparam logic [CW-1:0] PAD_LO  = CW'(R);
  localparam logic [CW-1:0] PAD_BOT = CW'(IMG_H - 1 - R);
  localparam logic [CW-1:0] PAD_RGT = CW'(IMG_W - 1 - R);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_stride2;
  logic [1:0]    w_step;
  logic [CW-1:0] w_col_lim;
  logic [CW-1:0] w_row_lim;
  logic          w_valid;
  logic          w_start_acc;
  logic          w_adv;
  logic          w_col_wrap;
  logic          w_row_wrap;

  assign w_valid     = (r_state == ST_RUN);
  assign w_start_acc = (r_state == ST_IDLE) & start;
  // abort wins over a handshake presented in the same cycle
  assign w_adv       = w_valid & out_ready & ~abort;

  // Stride-dependent step size and last aligned row/column
  always_comb begin
    if (r_stride2 == STRIDE_2) begin
      w_step    = 2'd2;
      w_col_lim = LC_S2;
      w_row_lim = LR_S2;
    end else begin
      w_step    = 2'd1;
      w_col_lim = LC_S1;
      w_row_lim = LR_S1;
    end
  end

  axis_stride_counter #(.CW(CW)) u_col_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_start_acc),
    .enable (w_adv),
    .stride (w_step),
    .limit  (w_col_lim),
    .count  (col),
    .wrap   (w_col_wrap)
  );

  // Row advances only when the column wraps on an accepted handshake
  axis_stride_counter #(.CW(CW)) u_row_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_start_acc),
    .enable (w_adv & w_col_wrap),
    .stride (w_step),
    .limit  (w_row_lim),
    .count  (row),
    .wrap   (w_row_wrap)
  );

  // Scan FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_adv & w_col_wrap & w_row_wrap) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Scan FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stride selector, captured only when a scan is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stride2 <= STRIDE_1;
    end else if (w_start_acc) begin
      r_stride2 <= stride2;
    end else begin
      r_stride2 <= r_stride2;
    end
  end

  assign out_valid = w_valid;
  assign busy      = w_valid;
  assign done      = (r_state == ST_DONE);

  // Flags are forced low outside RUN so reset/idle present all zeros
  assign pad_top    = w_valid & (row < PAD_LO);
  assign pad_bottom = w_valid & (row > PAD_BOT);
  assign pad_left   = w_valid & (col < PAD_LO);
  assign pad_right  = w_valid & (col > PAD_RGT);
  assign last_col   = w_valid & (col == w_col_lim);
  assign last_frame = w_valid & (col == w_col_lim) & (row == w_row_lim);

endmodule

// File: doc/frame_scan_sequencer.md
Name: frame_scan_sequencer

Overview:
Sequences the sliding-window scan of one IMG_W x IMG_H feature map for the convolution datapath. It emits window-centre coordinates (row, col) one per valid/ready handshake, at stride 1 or 2, with border flags for zero-padding. It sits between the layer controller (start/done) and the line-buffer/MAC array (consumer of coordinates).

Parameters:
IMG_W, 640, frame width in pixels
IMG_H, 640, frame height in pixels
CW, 10, coordinate width; must hold IMG_W-1 and IMG_H-1
KSIZE, 3, kernel size, odd; padding radius R = (KSIZE-1)/2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin a frame scan; sampled only in IDLE
stride2  in  1  0 = stride 1, 1 = stride 2; latched on accepted start
abort  in  1  synchronous cancel of a scan in progress
out_ready  in  1  consumer accepts the current coordinate
out_valid  out  1  coordinate outputs are valid
row  out  CW  window-centre row
col  out  CW  window-centre column
pad_top, pad_bottom, pad_left, pad_right  out  1 each  window overlaps that frame border
last_col  out  1  current coordinate is the last of its row
last_frame  out  1  current coordinate is the last of the frame
busy  out  1  high while in RUN
done  out  1  one-cycle pulse on scan completion

Behaviour:
- Reset (async, any state): state IDLE; row=col=0; out_valid, busy, done, last_* and pad_* all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 latches stride2, clears row/col, moves to RUN. out_valid=1 with (0,0) on the next cycle (1-cycle latency).
- RUN: out_valid=1, busy=1. A handshake is out_valid & out_ready.
  - On handshake, col += S (S = 1 or 2).
  - If col is the last column (LC = largest multiple of S <= IMG_W-1: 639 for S=1, 638 for S=2), col wraps to 0 and row += S.
  - If row is also the last row (LR, computed the same way from IMG_H), go to DONE.
- Backpressure: while out_valid & !out_ready, all outputs hold their values exactly. No advance.
- DONE: out_valid=0, busy=0, done=1 for exactly one cycle, then IDLE. Final handshake at cycle T gives done at T+1.
- abort in RUN: next cycle goes to IDLE with out_valid=0 and no done pulse. abort takes priority over a same-cycle handshake. abort in IDLE or DONE is ignored.
- start outside IDLE is ignored. stride2 changes outside an accepted start have no effect.
- Flags (combinational from registered row/col, valid only with out_valid):
  - pad_top = row < R; pad_bottom = row > IMG_H-1-R
  - pad_left = col < R; pad_right = col > IMG_W-1-R
  - last_col = (col == LC); last_frame = last_col & (row == LR)
- Arithmetic: the col+S and row+S comparisons are done at CW+1 bits, so there is no overflow at the top of range.
- Handshake counts: 409600 for stride 1, 102400 for stride 2 (640x640).

Decomposition:
- Package scan_pkg holds:
  - default IMG_W, IMG_H, CW, KSIZE
  - the state enum (IDLE, RUN, DONE)
  - stride encoding constants
  - a function computing the last aligned index for a given size and stride
- One sub-module, axis_stride_counter, is instantiated twice (column, row).
  - Ports: clk, rst, clear, enable, stride, limit → count, wrap.
  - The column counter's wrap, ANDed with the handshake, is a synchronous enable for the row counter. All logic is on clk; there are no derived clocks.

Test Plan:
- Async reset: assert rst mid-RUN at (5,9) → within the same cycle out_valid=0, busy=0, row=col=0, done=0; start after release gives (0,0).
- Stride 1, out_ready=1: start → 409600 handshakes.
  - First: (0,0) with pad_top=pad_left=1.
  - #640: (0,639) with last_col=pad_right=1.
  - #641: (1,0).
  - Last: (639,639) with last_frame=1; done=1 exactly one cycle later; busy=0.
- Stride 2: 102400 handshakes. Columns run 0,2,…,638, then row 2 col 0. pad_right and pad_bottom are never set. Last coordinate (638,638) with last_frame=1.
- Backpressure: drop out_ready for 5 cycles while presenting (3,7) → row, col and flags are stable and out_valid stays 1; after ready returns, the next coordinate is (3,8).
- abort at (10,20) with out_ready=1 → no handshake counted; IDLE next cycle; done never pulses; a new start begins at (0,0).
- start pulses and stride2 toggles during RUN → no effect on the sequence; total handshake count is unchanged.
